// File: rtl/pi_pkg.sv
// Shared types and constants for the PI loop sequencer.
// Holds the sequencer state encoding and the DAC clamp limit helpers.
package pi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_OUTPUT = 2'd2
    } pi_state_e;

    localparam int PI_ORB_DEFAULT = 20;
    localparam int PI_SAT_W       = 16;

    // Largest positive code of a signed orb-bit DAC word.
    function automatic logic [31:0] pi_out_max(input int orb);
        pi_out_max = (32'd1 << (orb - 1)) - 32'd1;
    endfunction

    // Most negative code of a signed orb-bit DAC word (low orb bits).
    function automatic logic [31:0] pi_out_min(input int orb);
        pi_out_min = ~pi_out_max(orb);
    endfunction

endpackage

// File: rtl/pi_output_clamp.sv
// Output clamp: maps pipeline flags and result onto a signed DAC code.
// Underflow takes priority over overflow when both are reported.
module pi_output_clamp
    import pi_pkg::*;
#(
    parameter int ORB = PI_ORB_DEFAULT
) (
    input  logic           overflow_i,
    input  logic           underflow_i,
    input  logic [ORB-1:0] pi_result_i,
    output logic [ORB-1:0] code_o,
    output logic           sat_o
);

    localparam logic [ORB-1:0] PI_OUT_MAX = ORB'(pi_out_max(ORB));
    localparam logic [ORB-1:0] PI_OUT_MIN = ORB'(pi_out_min(ORB));

    // Select the rail on saturation, otherwise pass the result through.
    always_comb begin
        code_o = pi_result_i;
        if (underflow_i) begin
            code_o = PI_OUT_MIN;
        end else if (overflow_i) begin
            code_o = PI_OUT_MAX;
        end
    end

    assign sat_o = overflow_i | underflow_i;

endmodule

// File: rtl/pi_loop_sequencer.sv
// PI loop sequencer: accepts ADC samples, drives one pipeline run per
// sample, owns the integral state and hands a clamped code to the DAC.
module pi_loop_sequencer
    import pi_pkg::*;
#(
    parameter int INPUT_WIDTH       = 18,
    parameter int OUTPUT_WIDTH      = 32,
    parameter int OUTPUT_RANGE_BITS = PI_ORB_DEFAULT,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         integral_clear,
    input  logic                         err_clear,
    input  logic [OUTPUT_WIDTH-1:0]      kp,
    input  logic [OUTPUT_WIDTH-1:0]      ki,
    input  logic [INPUT_WIDTH-1:0]       setpoint,
    input  logic                         adc_valid,
    output logic                         adc_ready,
    input  logic [INPUT_WIDTH-1:0]       adc_data,
    output logic                         pipe_cyc,
    output logic [OUTPUT_WIDTH-1:0]      pipe_kp,
    output logic [OUTPUT_WIDTH-1:0]      pipe_ki,
    output logic [INPUT_WIDTH-1:0]       pipe_setpoint,
    output logic [INPUT_WIDTH-1:0]       pipe_actual,
    output logic [OUTPUT_WIDTH-1:0]      pipe_integral_input,
    input  logic                         pipe_result_valid,
    input  logic [OUTPUT_WIDTH-1:0]      pipe_integral_result,
    input  logic [OUTPUT_WIDTH-1:0]      pipe_pi_result,
    input  logic                         pipe_overflow,
    input  logic                         pipe_underflow,
    output logic                         dac_valid,
    input  logic                         dac_ready,
    output logic [OUTPUT_RANGE_BITS-1:0] dac_data,
    output logic [OUTPUT_WIDTH-1:0]      integral_out,
    output logic [PI_SAT_W-1:0]          sat_count,
    output logic                         timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    pi_state_e state_q, state_d;

    logic [OUTPUT_WIDTH-1:0]      kp_q, ki_q, integ_in_q;
    logic [INPUT_WIDTH-1:0]       sp_q, act_q;
    logic [TMO_W-1:0]             tmo_q;
    logic [OUTPUT_WIDTH-1:0]      integral_q, integral_d;
    logic [OUTPUT_RANGE_BITS-1:0] dac_q;
    logic [PI_SAT_W-1:0]          sat_cnt_q;
    logic                         terr_q;

    logic accept, result_ok, timeout;
    logic [OUTPUT_RANGE_BITS-1:0] clamp_code;
    logic clamp_sat;
    logic pi_hi_unused;

    // Upper result bits are discarded by the truncating DAC path.
    assign pi_hi_unused = ^pipe_pi_result[OUTPUT_WIDTH-1:OUTPUT_RANGE_BITS];

    pi_output_clamp #(
        .ORB(OUTPUT_RANGE_BITS)
    ) u_clamp (
        .overflow_i (pipe_overflow),
        .underflow_i(pipe_underflow),
        .pi_result_i(pipe_pi_result[OUTPUT_RANGE_BITS-1:0]),
        .code_o     (clamp_code),
        .sat_o      (clamp_sat)
    );

    assign adc_ready = enable & (state_q == ST_IDLE);
    assign pipe_cyc  = (state_q == ST_RUN);
    assign dac_valid = (state_q == ST_OUTPUT);

    // Sequencer next state; abort beats result, result beats timeout.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        result_ok = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (adc_valid && adc_ready) begin
                    state_d = ST_RUN;
                    accept  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pipe_result_valid) begin
                    state_d   = ST_OUTPUT;
                    result_ok = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (dac_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Integral update: saturated results leave it alone, clear wins.
    always_comb begin
        integral_d = integral_q;
        if (result_ok && !clamp_sat) begin
            integral_d = pipe_integral_result;
        end
        if (integral_clear) begin
            integral_d = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand snapshot at sample accept, held for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_q       <= '0;
            ki_q       <= '0;
            sp_q       <= '0;
            act_q      <= '0;
            integ_in_q <= '0;
        end else if (accept) begin
            kp_q       <= kp;
            ki_q       <= ki;
            sp_q       <= setpoint;
            act_q      <= adc_data;
            integ_in_q <= integral_q;
        end
    end

    // Timeout counter, restarted per sample and advanced while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (accept) begin
            tmo_q <= '0;
        end else if (state_q == ST_RUN) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Integral, DAC code and saturation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integral_q <= '0;
            dac_q      <= '0;
            sat_cnt_q  <= '0;
        end else begin
            integral_q <= integral_d;
            if (result_ok) begin
                dac_q <= clamp_code;
            end
            if (result_ok && clamp_sat && sat_cnt_q != '1) begin
                sat_cnt_q <= sat_cnt_q + 1'b1;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terr_q <= 1'b0;
        end else if (timeout) begin
            terr_q <= 1'b1;
        end else if (err_clear) begin
            terr_q <= 1'b0;
        end
    end

    assign pipe_kp             = kp_q;
    assign pipe_ki             = ki_q;
    assign pipe_setpoint       = sp_q;
    assign pipe_actual         = act_q;
    assign pipe_integral_input = integ_in_q;
    assign dac_data            = dac_q;
    assign integral_out        = integral_q;
    assign sat_count           = sat_cnt_q;
    assign timeout_err         = terr_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Directed bench for the PI loop sequencer with a small pipeline model.
// Expected values are hand-computed constants per scenario.
module tb_pi_loop_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, integral_clear, err_clear;
    logic [31:0] kp, ki;
    logic [17:0] setpoint;
    logic        adc_valid, adc_ready;
    logic [17:0] adc_data;
    logic        pipe_cyc;
    logic [31:0] pipe_kp, pipe_ki, pipe_integral_input;
    logic [17:0] pipe_setpoint, pipe_actual;
    logic        pipe_result_valid;
    logic [31:0] pipe_integral_result, pipe_pi_result;
    logic        pipe_overflow, pipe_underflow;
    logic        dac_valid, dac_ready;
    logic [19:0] dac_data;
    logic [31:0] integral_out;
    logic [15:0] sat_count;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int mode  = 0;
    int mcnt  = 0;
    logic stray = 1'b0;

    always #5 clk = ~clk;

    pi_loop_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .integral_clear      (integral_clear),
        .err_clear           (err_clear),
        .kp                  (kp),
        .ki                  (ki),
        .setpoint            (setpoint),
        .adc_valid           (adc_valid),
        .adc_ready           (adc_ready),
        .adc_data            (adc_data),
        .pipe_cyc            (pipe_cyc),
        .pipe_kp             (pipe_kp),
        .pipe_ki             (pipe_ki),
        .pipe_setpoint       (pipe_setpoint),
        .pipe_actual         (pipe_actual),
        .pipe_integral_input (pipe_integral_input),
        .pipe_result_valid   (pipe_result_valid),
        .pipe_integral_result(pipe_integral_result),
        .pipe_pi_result      (pipe_pi_result),
        .pipe_overflow       (pipe_overflow),
        .pipe_underflow      (pipe_underflow),
        .dac_valid           (dac_valid),
        .dac_ready           (dac_ready),
        .dac_data            (dac_data),
        .integral_out        (integral_out),
        .sat_count           (sat_count),
        .timeout_err         (timeout_err)
    );

    // Pipeline model: result on the 5th edge after accept.
    // mode 0 normal, 1 overflow, 2 underflow, 3 silent, 4 both flags.
    always @(negedge clk) begin
        logic signed [31:0] err, integ;
        err   = {{14{pipe_actual[17]}}, pipe_actual}
              - {{14{pipe_setpoint[17]}}, pipe_setpoint};
        integ = pipe_integral_input + err;
        if (pipe_cyc) mcnt <= mcnt + 1;
        else mcnt <= 0;
        if (pipe_cyc && mode != 3 && mcnt == 4) begin
            pipe_result_valid    <= 1'b1;
            pipe_integral_result <= integ;
            pipe_pi_result       <= pipe_kp * err + pipe_ki * integ;
            pipe_overflow        <= (mode == 1 || mode == 4);
            pipe_underflow       <= (mode == 2 || mode == 4);
        end else begin
            pipe_result_valid    <= stray;
            pipe_integral_result <= 32'h0BAD_0000;
            pipe_pi_result       <= 32'h0000_1234;
            pipe_overflow        <= stray;
            pipe_underflow       <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample and return at the negedge after the accept edge.
    task automatic send(input logic [17:0] d);
        int n = 0;
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = d;
        while (!adc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("adc_ready_wait", adc_ready, 1);
        @(posedge clk);
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    // Negedges from accept (counting the first as 1) until dac_valid.
    task automatic wait_dac(output int lat);
        lat = 1;
        while (!dac_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, c, dv, held;
        rst_n = 1'b0;
        enable = 1'b0;
        integral_clear = 1'b0;
        err_clear = 1'b0;
        kp = 32'd1;
        ki = 32'd0;
        setpoint = '0;
        adc_valid = 1'b0;
        adc_data = '0;
        dac_ready = 1'b1;
        pipe_result_valid = 1'b0;
        pipe_integral_result = '0;
        pipe_pi_result = '0;
        pipe_overflow = 1'b0;
        pipe_underflow = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_pipe_cyc", pipe_cyc, 0);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_integral", integral_out, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_pipe_kp", pipe_kp, 0);
        check("rst_adc_ready", adc_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        #1 check("idle_adc_ready", adc_ready, 1);

        // Nominal computation.
        send(18'h00100);
        wait_dac(lat);
        check("t1_latency", lat, 6);
        check("t1_dac_data", dac_data, 20'h00100);
        check("t1_integral", integral_out, 32'h100);
        @(negedge clk);
        check("t1_dac_done", dac_valid, 0);
        check("t1_ready_back", adc_ready, 1);

        // Saturation paths.
        mode = 1;
        send(18'h00050);
        wait_dac(lat);
        check("t2_ovf_dac", dac_data, 20'h7FFFF);
        check("t2_ovf_integral", integral_out, 32'h100);
        check("t2_ovf_sat", sat_count, 1);
        mode = 2;
        send(18'h00050);
        wait_dac(lat);
        check("t2_unf_dac", dac_data, 20'h80000);
        check("t2_unf_sat", sat_count, 2);
        mode = 4;
        send(18'h00050);
        wait_dac(lat);
        check("t2_both_dac", dac_data, 20'h80000);
        check("t2_both_sat", sat_count, 3);
        check("t2_both_integral", integral_out, 32'h100);
        mode = 0;

        // Stray result strobe while idle.
        @(negedge clk);
        #1 stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stray_dac_valid", dac_valid, 0);
        check("stray_sat", sat_count, 3);
        check("stray_integral", integral_out, 32'h100);
        stray = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout.
        mode = 3;
        send(18'h00060);
        c = 0;
        dv = 0;
        while (pipe_cyc && c < 40) begin
            c++;
            if (dac_valid) dv++;
            @(negedge clk);
        end
        check("t3_cyc_len", c, 15);
        check("t3_no_dac", dv, 0);
        check("t3_timeout_err", timeout_err, 1);
        check("t3_ready_back", adc_ready, 1);
        check("t3_integral", integral_out, 32'h100);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t3_err_cleared", timeout_err, 0);

        // Timeout and clear in the same cycle: set wins.
        err_clear = 1'b1;
        send(18'h00060);
        c = 0;
        while (pipe_cyc && c < 40) begin
            c++;
            @(negedge clk);
        end
        check("t3b_set_wins", timeout_err, 1);
        err_clear = 1'b0;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t3b_cleared", timeout_err, 0);
        mode = 0;

        // Backpressure, operand snapshot, enable low during output.
        dac_ready = 1'b0;
        send(18'h00020);
        check("t4_pipe_actual", pipe_actual, 18'h00020);
        check("t4_pipe_integ_in", pipe_integral_input, 32'h100);
        kp = 32'd7;
        @(negedge clk);
        check("t4_pipe_kp_held", pipe_kp, 1);
        kp = 32'd1;
        wait_dac(lat);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dac_valid && dac_data == 20'h00020 && !adc_ready) held++;
            if (i == 4) enable = 1'b0;
        end
        check("t4_held", held, 10);
        enable = 1'b1;
        dac_ready = 1'b1;
        @(negedge clk);
        check("t4_released", dac_valid, 0);
        check("t4_integral", integral_out, 32'h120);

        // Enable dropped while running.
        send(18'h00030);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_abort_cyc", pipe_cyc, 0);
        dv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dac_valid) dv++;
        end
        check("t5_no_dac", dv, 0);
        check("t5_integral", integral_out, 32'h120);
        enable = 1'b1;

        // Clear coincident with a result write: clear wins.
        send(18'h00040);
        repeat (4) @(negedge clk);
        #1;
        check("t5_rv_seen", pipe_result_valid, 1);
        integral_clear = 1'b1;
        @(negedge clk);
        integral_clear = 1'b0;
        check("t5_clr_dac_valid", dac_valid, 1);
        check("t5_clr_dac", dac_data, 20'h00040);
        check("t5_clr_integral", integral_out, 0);

        // Back-to-back samples with adc_valid held high.
        ki = 32'd1;
        @(negedge clk);
        adc_data = 18'h00010;
        adc_valid = 1'b1;
        dv = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (dac_valid) dv++;
        end
        adc_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dac_valid) dv++;
        end
        check("t6_count", dv, 3);
        check("t6_integral", integral_out, 32'h30);
        check("t6_dac", dac_data, 20'h00040);
        check("t6_sat", sat_count, 3);

        // Reset in the middle of a run.
        send(18'h00010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", pipe_cyc, 0);
        check("rst_mid_integral", integral_out, 0);
        check("rst_mid_sat", sat_count, 0);
        check("rst_mid_dac", dac_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
